// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity selectors and the default bit timing
// for a 100 MHz clock at 115200 baud.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the wrap cycle.
// Shared between the transmitter and the future receiver.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = en & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// tx, tx_busy and tx_done are all registered.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   ST_IDLE   | line high, waiting for a qualified request
//   ST_START  | start bit (tx=0), one bit period
//   ST_DATA   | data bits, LSB first, one bit period each
//   ST_PARITY | parity of the latched byte, one bit period
//   ST_STOP   | line high for STOP_BITS bit periods
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int START_EDGE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_t state;
    logic        start_d;
    logic        req;
    logic        tick;
    logic        baud_en;
    logic        baud_clr;
    logic [7:0]  shift;
    logic        par_bit;
    logic [2:0]  bit_idx;
    logic        stop_cnt;

    // Edge mode keeps a held button from retriggering once the frame ends.
    assign req      = (START_EDGE != 0) ? (tx_start & ~start_d) : tx_start;
    assign baud_en  = (state != ST_IDLE);
    assign baud_clr = (state == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (baud_en),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            start_d  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            start_d <= tx_start;
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (req) begin
                        shift    <= tx_data;
                        par_bit  <= (PARITY == PAR_EVEN) ? ^tx_data : ~^tx_data;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= ST_START;
                        tx_busy  <= 1'b1;
                        tx       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (STOP_BITS == 1 || stop_cnt) begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                        tx <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five configurations side by side, each checked cycle by cycle
// against an expected bit list built from the framing rules.
module tb_uart_tx_frame;

    localparam int CPB = 4;
    localparam int N   = 5;
    // inst 0: none/1 stop/edge, 1: even, 2: odd, 3: 2 stop bits, 4: level start
    localparam int PAR_C[N]  = '{0, 2, 1, 0, 0};
    localparam int STOP_C[N] = '{1, 1, 1, 2, 1};

    logic         clk;
    logic [N-1:0] rst_n_v;
    logic [N-1:0] tx_start_v;
    logic [7:0]   tx_data_v [N];
    logic [N-1:0] tx_v;
    logic [N-1:0] busy_v;
    logic [N-1:0] done_v;

    int n_cmp;
    int n_err;
    logic exp_q[$];

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .START_EDGE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .tx_data(tx_data_v[0]), .tx_start(tx_start_v[0]),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .START_EDGE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .tx_data(tx_data_v[1]), .tx_start(tx_start_v[1]),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .START_EDGE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n_v[2]), .tx_data(tx_data_v[2]), .tx_start(tx_start_v[2]),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2), .START_EDGE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n_v[3]), .tx_data(tx_data_v[3]), .tx_start(tx_start_v[3]),
        .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .START_EDGE(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n_v[4]), .tx_data(tx_data_v[4]), .tx_start(tx_start_v[4]),
        .tx(tx_v[4]), .tx_busy(busy_v[4]), .tx_done(done_v[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected line levels, one entry per bit period, from the framing rules.
    function automatic void build_frame(input int k, input logic [7:0] d);
        int ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (PAR_C[k] == 2) exp_q.push_back((ones % 2) == 1);
        if (PAR_C[k] == 1) exp_q.push_back((ones % 2) == 0);
        for (int i = 0; i < STOP_C[k]; i++) exp_q.push_back(1'b1);
    endfunction

    // Starts from a negedge; the following posedge is the acceptance edge.
    task automatic run_frame(input int k, input logic [7:0] d, input int hold,
                             input bit poke, input int rst_at);
        int len;
        build_frame(k, d);
        len = exp_q.size() * CPB;
        tx_data_v[k]  = d;
        tx_start_v[k] = 1'b1;
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            if (c + 1 >= hold) tx_start_v[k] = 1'b0;
            if (poke && c == 10) begin
                tx_start_v[k] = 1'b1;
                tx_data_v[k]  = ~d;
            end
            if (poke && c == 11) tx_start_v[k] = 1'b0;
            if (c == rst_at) begin
                rst_n_v[k] = 1'b0;
                #1;
                chk("rst_tx", tx_v[k], 1'b1);
                chk("rst_busy", busy_v[k], 1'b0);
                chk("rst_done", done_v[k], 1'b0);
                @(negedge clk);
                rst_n_v[k] = 1'b1;
                return;
            end
            if (c < len) begin
                chk("tx", tx_v[k], exp_q[c / CPB]);
                chk("busy", busy_v[k], 1'b1);
                chk("done_early", done_v[k], 1'b0);
            end else begin
                chk("end_tx", tx_v[k], 1'b1);
                chk("end_busy", busy_v[k], 1'b0);
                chk("end_done", done_v[k], 1'b1);
            end
        end
    endtask

    task automatic idle_check(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx", tx_v[k], 1'b1);
            chk("idle_busy", busy_v[k], 1'b0);
            chk("idle_done", done_v[k], 1'b0);
        end
    endtask

    initial begin
        int k;
        logic [7:0] d;
        bit poke;
        n_cmp = 0;
        n_err = 0;
        rst_n_v    = '0;
        tx_start_v = '0;
        for (int i = 0; i < N; i++) tx_data_v[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("reset_tx", tx_v[i], 1'b1);
            chk("reset_busy", busy_v[i], 1'b0);
            chk("reset_done", done_v[i], 1'b0);
        end
        rst_n_v = '1;
        for (int i = 0; i < N; i++) idle_check(i, 2);

        // basic 8N1 frame
        run_frame(0, 8'hA5, 1, 1'b0, -1);
        idle_check(0, 3);

        // even / odd parity
        run_frame(1, 8'hA5, 1, 1'b0, -1);
        idle_check(1, 2);
        run_frame(2, 8'hA5, 1, 1'b0, -1);
        idle_check(2, 2);
        run_frame(1, 8'h07, 1, 1'b0, -1);
        idle_check(1, 2);

        // held button in edge mode: one frame only
        run_frame(0, 8'h5A, 100, 1'b0, -1);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (i == 60) tx_start_v[0] = 1'b0;
            chk("hold_tx", tx_v[0], 1'b1);
            chk("hold_busy", busy_v[0], 1'b0);
            chk("hold_done", done_v[0], 1'b0);
        end

        // level mode: back-to-back frames with one idle cycle
        run_frame(4, 8'h81, 1000, 1'b0, -1);
        run_frame(4, 8'h42, 1000, 1'b0, -1);
        run_frame(4, 8'h3C, 1, 1'b0, -1);
        idle_check(4, 3);

        // request and data change mid-frame are ignored
        run_frame(0, 8'hC3, 1, 1'b1, -1);
        idle_check(0, 3);

        // reset mid-DATA, then a clean frame
        run_frame(0, 8'h96, 1, 1'b0, 17);
        idle_check(0, 3);
        run_frame(0, 8'h3C, 1, 1'b0, -1);
        idle_check(0, 2);

        // two stop bits
        run_frame(3, 8'hFF, 1, 1'b0, -1);
        idle_check(3, 2);

        for (int r = 0; r < 40; r++) begin
            k    = int'($urandom_range(0, N - 1));
            d    = 8'($urandom);
            poke = ($urandom_range(0, 3) == 0);
            run_frame(k, d, 1, poke, -1);
            idle_check(k, int'($urandom_range(1, 5)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
